// File: rtl/sr_iter.sv
// rtl/sr_iter.sv - iterative right shifter (srl/sra/srlv/srav), STEP bits per clock
// start/done handshake so the execute-stage control FSM can stall while it runs.
module sr_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outp
);

  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    rem;
  logic             fill;

  logic [SW-1:0]    s;
  logic [SW-1:0]    rem_next;
  logic [WIDTH-1:0] work_next;

  // Step is clamped to what is left so the last step may be partial.
  always_comb begin
    s         = (rem < STEP_W) ? rem : STEP_W;
    rem_next  = rem - s;
    work_next = WIDTH'({{WIDTH{fill}}, work} >> s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      outp  <= '0;
      work  <= '0;
      rem   <= '0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work <= in;
            rem  <= shamt;
            fill <= arith & in[WIDTH-1];
            busy <= 1'b1;
            if (shamt == '0) begin
              state <= DONE;
              done  <= 1'b1;
              outp  <= in;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          rem  <= rem_next;
          if (rem_next == '0) begin
            state <= DONE;
            done  <= 1'b1;
            outp  <= work_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_iter.sv
// tb/tb_sr_iter.sv - self-checking bench for sr_iter against a shift reference model
module tb_sr_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] outp;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_out;

  sr_iter #(.WIDTH(32), .STEP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in), .shamt(shamt),
    .arith(arith), .busy(busy), .done(done), .outp(outp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n, input logic ar);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = {ar ? r[31] : 1'b0, r[31:1]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; with poke set, new operands and start are driven every cycle while busy.
  task automatic run_op(input logic [31:0] a, input int n, input logic ar, input bit poke);
    int cnt;
    int steps;
    logic [31:0] exp;
    exp   = ref_shift(a, n, ar);
    steps = (n + 1) / 2;
    in = a; shamt = 5'(n); arith = ar; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin
      chk("busy_during_shift", {31'b0, busy}, 32'd1);
      chk("outp_stable", outp, last_out);
      if (poke) begin
        start = 1'b1; in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
      end
      tick();
      cnt++;
    end
    chk("latency", cnt, steps);
    chk("result", outp, exp);
    chk("busy_in_done", {31'b0, busy}, 32'd1);
    last_out = exp;
    if (poke) begin
      start = 1'b1; in = $urandom;
    end
    tick();
    start = 1'b0;
    chk("done_pulse_one_cycle", {31'b0, done}, 32'd0);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    tick();
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    chk("outp_hold_idle", outp, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in = '0; shamt = '0; arith = 1'b0;
    last_out = '0;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_outp", outp, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    run_op(32'h80000000, 4, 1'b0, 1'b0);
    chk("srl_known", outp, 32'h08000000);
    run_op(32'h80000000, 4, 1'b1, 1'b0);
    chk("sra_neg_known", outp, 32'hF8000000);
    run_op(32'h7FFFFFFF, 4, 1'b1, 1'b0);
    chk("sra_pos_known", outp, 32'h07FFFFFF);
    run_op(32'h12345678, 0, 1'b0, 1'b0);
    chk("shamt0_known", outp, 32'h12345678);
    run_op(32'hFFFFFFE0, 5, 1'b0, 1'b0);
    chk("partial_step_known", outp, 32'h07FFFFFF);
    run_op(32'h80000001, 31, 1'b1, 1'b0);
    chk("sra31_known", outp, 32'hFFFFFFFF);
    run_op(32'h80000001, 31, 1'b0, 1'b0);
    run_op(32'hA5A5A5A5, 7, 1'b1, 1'b1);
    run_op(32'h0F0F0F0F, 0, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++)
      run_op($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));

    // Abort mid-shift
    in = 32'hDEADBEEF; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_outp", outp, 32'd0);
    tick();
    reset = 1'b0;
    last_out = '0;
    for (int i = 0; i < 20; i++) begin
      chk("no_done_after_abort", {31'b0, done}, 32'd0);
      tick();
    end
    run_op(32'hC0000000, 3, 1'b1, 1'b0);
    chk("after_reset_known", outp, 32'hF8000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
